// File: rtl/vga_pkg.sv
// Shared VGA raster constants and zoom geometry helpers.
// The zoom stages and the framebuffer reader decode zoom codes identically.
package vga_pkg;

  // 640x480@60 Hz raster, in pixels and lines
  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int VGA_H_TOTAL      = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC - 1;

  typedef enum logic [2:0] {
    ZOOM_40X30   = 3'd0,
    ZOOM_80X60   = 3'd1,
    ZOOM_160X120 = 3'd2,
    ZOOM_320X240 = 3'd3
  } zoom_t;

  typedef struct packed {
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] x_off;
    logic [9:0] y_off;
  } zoom_geom_t;

  // Codes 4..7 are not real sizes and fall back to the middle size.
  function automatic zoom_t zoom_norm(input logic [2:0] code);
    zoom_t z;
    case (code)
      3'd0:    z = ZOOM_40X30;
      3'd1:    z = ZOOM_80X60;
      3'd2:    z = ZOOM_160X120;
      3'd3:    z = ZOOM_320X240;
      default: z = ZOOM_160X120;
    endcase
    return z;
  endfunction

  // Image size and the offsets that centre it on the visible area.
  function automatic zoom_geom_t zoom_geom(input logic [2:0] code);
    zoom_geom_t g;
    logic [9:0] dx;
    logic [9:0] dy;
    g = '0;
    case (zoom_norm(code))
      ZOOM_40X30:   begin g.w = 10'd40;  g.h = 10'd30;  end
      ZOOM_80X60:   begin g.w = 10'd80;  g.h = 10'd60;  end
      ZOOM_160X120: begin g.w = 10'd160; g.h = 10'd120; end
      ZOOM_320X240: begin g.w = 10'd320; g.h = 10'd240; end
      default:      begin g.w = 10'd160; g.h = 10'd120; end
    endcase
    dx = 10'(VGA_H_VIS) - g.w;
    dy = 10'(VGA_V_VIS) - g.h;
    g.x_off = {1'b0, dx[9:1]};
    g.y_off = {1'b0, dy[9:1]};
    return g;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: pixel tick, h/v counters, sync/blank (one tick behind the
// counters) and the frame_start pulse.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS        = VGA_H_VIS,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_END   = VGA_H_SYNC_END,
  parameter int V_VIS        = VGA_V_VIS,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_END   = VGA_V_SYNC_END
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       frame_wrap,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       frame_start,
  output logic       vga_clk
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0] VS_START = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END   = 10'(V_SYNC_END);

  logic       tick_r;
  logic       vga_clk_r;
  logic [9:0] h_r;
  logic [9:0] v_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       blank_n_r;
  logic       frame_start_r;

  logic       h_last_s;
  logic       v_last_s;
  logic       wrap_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic       vis_s;

  // Decode the current counter state into wrap, sync and visible flags
  always_comb begin
    h_last_s = (h_r == H_LAST);
    v_last_s = (v_r == V_LAST);
    wrap_s   = tick_r && h_last_s && v_last_s;
    hs_raw_s = !((h_r >= HS_START) && (h_r <= HS_END));
    vs_raw_s = !((v_r >= VS_START) && (v_r <= VS_END));
    vis_s    = (h_r < H_VIS_C) && (v_r < V_VIS_C);
  end

  // Pixel tick and the pixel clock; vga_clk falls on the edge where pixels change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r    <= 1'b0;
      vga_clk_r <= 1'b1;
    end else begin
      tick_r    <= ~tick_r;
      vga_clk_r <= ~tick_r;
    end
  end

  // Raster counters and stage-B sync/blank, advanced on tick clocks only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r       <= 10'd0;
      v_r       <= 10'd0;
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (tick_r) begin
      hsync_r   <= hs_raw_s;
      vsync_r   <= vs_raw_s;
      blank_n_r <= vis_s;
      if (h_last_s) begin
        h_r <= 10'd0;
        if (v_last_s) begin
          v_r <= 10'd0;
        end else begin
          v_r <= v_r + 10'd1;
        end
      end else begin
        h_r <= h_r + 10'd1;
      end
    end else begin
      h_r <= h_r;
      v_r <= v_r;
    end
  end

  // One-clock pulse as the counters enter (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= wrap_s;
    end
  end

  assign tick        = tick_r;
  assign h_cnt       = h_r;
  assign v_cnt       = v_r;
  assign frame_wrap  = wrap_s;
  assign hsync_n     = hsync_r;
  assign vsync_n     = vsync_r;
  assign blank_n     = blank_n_r;
  assign frame_start = frame_start_r;
  assign vga_clk     = vga_clk_r;

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Reads the zoomed grayscale image from the framebuffer and centres it on a
// 640x480 VGA raster. Pipeline: counters -> address/flags -> pixel/sync pins.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  zoom_level,
  input  logic [7:0]  fb_data,
  output logic [16:0] fb_addr,
  output logic [7:0]  vga_pixel,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_clk,
  output logic        frame_start
);

  logic        tick_s;
  logic [9:0]  h_s;
  logic [9:0]  v_s;
  logic        frame_wrap_s;
  logic        hsync_b_s;
  logic        vsync_b_s;
  logic        blank_b_s;

  zoom_t       zoom_q_r;
  zoom_geom_t  geom_s;
  logic [9:0]  x_end_s;
  logic [9:0]  y_end_s;
  logic [9:0]  rel_x_s;
  logic [9:0]  rel_y_s;
  logic        in_win_s;
  logic [16:0] addr_s;

  logic [16:0] fb_addr_r;
  logic        in_win_d_r;
  logic [7:0]  pixel_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_n_r;

  vga_timing #(
    .H_VIS        (H_VIS),
    .H_TOTAL      (H_VIS + H_FP + H_SYNC + H_BP),
    .H_SYNC_START (H_VIS + H_FP),
    .H_SYNC_END   (H_VIS + H_FP + H_SYNC - 1),
    .V_VIS        (V_VIS),
    .V_TOTAL      (V_VIS + V_FP + V_SYNC + V_BP),
    .V_SYNC_START (V_VIS + V_FP),
    .V_SYNC_END   (V_VIS + V_FP + V_SYNC - 1)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick_s),
    .h_cnt       (h_s),
    .v_cnt       (v_s),
    .frame_wrap  (frame_wrap_s),
    .hsync_n     (hsync_b_s),
    .vsync_n     (vsync_b_s),
    .blank_n     (blank_b_s),
    .frame_start (frame_start),
    .vga_clk     (vga_clk)
  );

  // Zoom is taken only at the frame wrap so a frame never mixes two sizes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zoom_q_r <= ZOOM_160X120;
    end else if (frame_wrap_s) begin
      zoom_q_r <= zoom_norm(zoom_level);
    end else begin
      zoom_q_r <= zoom_q_r;
    end
  end

  // Window test and row-major address for the current counter position
  always_comb begin
    geom_s   = zoom_geom(zoom_q_r);
    x_end_s  = geom_s.x_off + geom_s.w;
    y_end_s  = geom_s.y_off + geom_s.h;
    in_win_s = (h_s >= geom_s.x_off) && (h_s < x_end_s) &&
               (v_s >= geom_s.y_off) && (v_s < y_end_s);
    rel_x_s  = h_s - geom_s.x_off;
    rel_y_s  = v_s - geom_s.y_off;
    addr_s   = ({7'd0, rel_y_s} * {7'd0, geom_s.w}) + {7'd0, rel_x_s};
  end

  // Stage B: issue the read; outside the window the address is left alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_r  <= 17'd0;
      in_win_d_r <= 1'b0;
    end else if (tick_s) begin
      in_win_d_r <= in_win_s;
      if (in_win_s) begin
        fb_addr_r <= addr_s;
      end else begin
        fb_addr_r <= fb_addr_r;
      end
    end else begin
      in_win_d_r <= in_win_d_r;
    end
  end

  // Stage C: pixel mux and pins, aligned with the returned RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_r   <= 8'h00;
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (tick_s) begin
      pixel_r   <= (in_win_d_r && blank_b_s) ? fb_data : 8'h00;
      hsync_r   <= hsync_b_s;
      vsync_r   <= vsync_b_s;
      blank_n_r <= blank_b_s;
    end else begin
      pixel_r   <= pixel_r;
    end
  end

  assign fb_addr     = fb_addr_r;
  assign vga_pixel   = pixel_r;
  assign vga_hsync   = hsync_r;
  assign vga_vsync   = vsync_r;
  assign vga_blank_n = blank_n_r;

endmodule
